// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem: bus width defaults and
// the master ID encoding used by the RAM arbiter and its round-robin picker.
package chip8_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 12;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    MASTER_NONE = 2'd0,
    MASTER_CPU  = 2'd1,
    MASTER_GPU  = 2'd2,
    MASTER_DISP = 2'd3
  } master_e;

  // Maps a one-hot reader mask {disp, gpu, cpu} to its master ID.
  function automatic master_e onehot_to_master(input logic [2:0] oh);
    master_e m;
    case (oh)
      3'b001:  m = MASTER_CPU;
      3'b010:  m = MASTER_GPU;
      3'b100:  m = MASTER_DISP;
      default: m = MASTER_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter3.sv
// Three-way round-robin picker: the search starts at the master after the last
// one granted and wraps CPU -> GPU -> DISP. Purely combinational.
module rr_arbiter3
  import chip8_pkg::*;
(
  input  logic [2:0] req,
  input  master_e    last,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    case (last)
      MASTER_CPU: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      MASTER_GPU: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port system RAM arbiter for CPU, GPU and display scanout. Writes take
// the RAM immediately (GPU beats CPU); reads are shared round-robin otherwise.
module mem_arbiter
  import chip8_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [ADDR_WIDTH-1:0] cpu_read_idx,
  output logic                  cpu_read_ack,
  output logic [DATA_WIDTH-1:0] cpu_read_byte,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_write_idx,
  input  logic [DATA_WIDTH-1:0] cpu_write_byte,
  input  logic                  gpu_read,
  input  logic [ADDR_WIDTH-1:0] gpu_read_idx,
  output logic                  gpu_read_ack,
  output logic [DATA_WIDTH-1:0] gpu_read_byte,
  input  logic                  gpu_write,
  input  logic [ADDR_WIDTH-1:0] gpu_write_idx,
  input  logic [DATA_WIDTH-1:0] gpu_write_byte,
  input  logic                  disp_read,
  input  logic [ADDR_WIDTH-1:0] disp_read_idx,
  output logic                  disp_read_ack,
  output logic [DATA_WIDTH-1:0] disp_read_byte,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  write_conflict
);

  master_e    tag_q, tag_d;
  master_e    last_q, last_d;
  logic       conflict_q;
  logic [2:0] req, ack, eligible, grant;

  // Reset masks the ack of a read that was in flight when reset arrived.
  assign cpu_read_ack  = (tag_q == MASTER_CPU)  && !reset;
  assign gpu_read_ack  = (tag_q == MASTER_GPU)  && !reset;
  assign disp_read_ack = (tag_q == MASTER_DISP) && !reset;

  assign cpu_read_byte  = ram_rdata;
  assign gpu_read_byte  = ram_rdata;
  assign disp_read_byte = ram_rdata;

  assign req      = {disp_read, gpu_read, cpu_read};
  assign ack      = {disp_read_ack, gpu_read_ack, cpu_read_ack};
  assign eligible = req & ~ack;

  assign write_conflict = conflict_q;

  rr_arbiter3 u_rr (
    .req   (eligible),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    tag_d     = MASTER_NONE;
    last_d    = last_q;
    if (!reset) begin
      if (gpu_write) begin
        ram_we    = 1'b1;
        ram_addr  = gpu_write_idx;
        ram_wdata = gpu_write_byte;
      end else if (cpu_write) begin
        ram_we    = 1'b1;
        ram_addr  = cpu_write_idx;
        ram_wdata = cpu_write_byte;
      end else if (grant != 3'b000) begin
        tag_d  = onehot_to_master(grant);
        last_d = tag_d;
        case (tag_d)
          MASTER_CPU:  ram_addr = cpu_read_idx;
          MASTER_GPU:  ram_addr = gpu_read_idx;
          MASTER_DISP: ram_addr = disp_read_idx;
          default:     ram_addr = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q      <= MASTER_NONE;
      last_q     <= MASTER_DISP;
      conflict_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      last_q <= last_d;
      if (cpu_write && gpu_write) conflict_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: a behavioural RAM sits behind the
// arbiter, and expected read results are queued at grant and popped at ack.
module tb_mem_arbiter;
  import chip8_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_read, cpu_write, gpu_read, gpu_write, disp_read;
  logic [AW-1:0] cpu_read_idx, cpu_write_idx, gpu_read_idx, gpu_write_idx, disp_read_idx;
  logic [DW-1:0] cpu_write_byte, gpu_write_byte;
  logic          cpu_read_ack, gpu_read_ack, disp_read_ack;
  logic [DW-1:0] cpu_read_byte, gpu_read_byte, disp_read_byte;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          write_conflict;

  typedef struct {
    master_e       m;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] model   [0:(1<<AW)-1];
  logic          exp_conflict;
  int            n_compared   = 0;
  int            n_mismatched = 0;

  always #5 clk = ~clk;

  // Registered-read RAM macro model
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_read_idx(cpu_read_idx), .cpu_read_ack(cpu_read_ack),
    .cpu_read_byte(cpu_read_byte), .cpu_write(cpu_write), .cpu_write_idx(cpu_write_idx),
    .cpu_write_byte(cpu_write_byte),
    .gpu_read(gpu_read), .gpu_read_idx(gpu_read_idx), .gpu_read_ack(gpu_read_ack),
    .gpu_read_byte(gpu_read_byte), .gpu_write(gpu_write), .gpu_write_idx(gpu_write_idx),
    .gpu_write_byte(gpu_write_byte),
    .disp_read(disp_read), .disp_read_idx(disp_read_idx), .disp_read_ack(disp_read_ack),
    .disp_read_byte(disp_read_byte),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .write_conflict(write_conflict)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic cr, input logic [AW-1:0] ci,
    input logic cw, input logic [AW-1:0] cwi, input logic [DW-1:0] cwb,
    input logic gr, input logic [AW-1:0] gi,
    input logic gw, input logic [AW-1:0] gwi, input logic [DW-1:0] gwb,
    input logic dr, input logic [AW-1:0] di);
    cpu_read  = cr; cpu_read_idx  = ci;
    cpu_write = cw; cpu_write_idx = cwi; cpu_write_byte = cwb;
    gpu_read  = gr; gpu_read_idx  = gi;
    gpu_write = gw; gpu_write_idx = gwi; gpu_write_byte = gwb;
    disp_read = dr; disp_read_idx = di;
  endtask

  // Checks this cycle's RAM-side outputs and any pending ack, then advances one cycle.
  task automatic checkOutput(input string tag, input logic exp_we, input logic [AW-1:0] exp_addr,
                             input logic [DW-1:0] exp_wdata, input master_e exp_grant);
    exp_t          e;
    logic [2:0]    ack_vec, exp_ack;
    logic [DW-1:0] obs_byte;
    @(negedge clk);
    ack_vec = {disp_read_ack, gpu_read_ack, cpu_read_ack};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.m)
        MASTER_CPU:  begin exp_ack = 3'b001; obs_byte = cpu_read_byte;  end
        MASTER_GPU:  begin exp_ack = 3'b010; obs_byte = gpu_read_byte;  end
        default:     begin exp_ack = 3'b100; obs_byte = disp_read_byte; end
      endcase
      cmp({tag, "/ack"}, 32'(ack_vec), 32'(exp_ack));
      cmp({tag, "/byte"}, 32'(obs_byte), 32'(e.data));
    end else begin
      cmp({tag, "/noack"}, 32'(ack_vec), 32'd0);
    end
    cmp({tag, "/we"}, 32'(ram_we), 32'(exp_we));
    cmp({tag, "/addr"}, 32'(ram_addr), 32'(exp_addr));
    cmp({tag, "/wdata"}, 32'(ram_wdata), 32'(exp_wdata));
    cmp({tag, "/conflict"}, 32'(write_conflict), 32'(exp_conflict));
    if (exp_grant != MASTER_NONE) sb.push_back('{exp_grant, model[exp_addr]});
    if (exp_we) model[exp_addr] = exp_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    exp_conflict = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("reset", 0, 12'h000, 8'h00, MASTER_NONE);
    reset = 1'b0;

    // Preload RAM through both write ports
    applyStimulus(0, 0, 1, 12'h200, 8'hA2, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre0", 1, 12'h200, 8'hA2, MASTER_NONE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h100, 8'h10, 0, 0);
    checkOutput("pre1", 1, 12'h100, 8'h10, MASTER_NONE);
    applyStimulus(0, 0, 1, 12'h101, 8'h11, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre2", 1, 12'h101, 8'h11, MASTER_NONE);

    applyStimulus(1, 12'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single", 0, 12'h200, 8'h00, MASTER_CPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_ack", 0, 12'h000, 8'h00, MASTER_NONE);

    reset = 1'b1;
    checkOutput("reset2", 0, 12'h000, 8'h00, MASTER_NONE);
    reset = 1'b0;

    applyStimulus(1, 12'h200, 0, 0, 0, 1, 12'h100, 0, 0, 0, 1, 12'h101);
    checkOutput("rr0", 0, 12'h200, 8'h00, MASTER_CPU);
    applyStimulus(0, 0, 0, 0, 0, 1, 12'h100, 0, 0, 0, 1, 12'h101);
    checkOutput("rr1", 0, 12'h100, 8'h00, MASTER_GPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h101);
    checkOutput("rr2", 0, 12'h101, 8'h00, MASTER_DISP);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr3", 0, 12'h000, 8'h00, MASTER_NONE);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h108, 8'h55, 1, 12'h100);
    checkOutput("wpre0", 1, 12'h108, 8'h55, MASTER_NONE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h100);
    checkOutput("wpre1", 0, 12'h100, 8'h00, MASTER_DISP);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wpre2", 0, 12'h000, 8'h00, MASTER_NONE);

    applyStimulus(0, 0, 0, 0, 0, 1, 12'h108, 0, 0, 0, 1, 12'h101);
    checkOutput("rmw0", 0, 12'h108, 8'h00, MASTER_GPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h108, 8'h56, 1, 12'h101);
    checkOutput("rmw1", 1, 12'h108, 8'h56, MASTER_NONE);
    applyStimulus(0, 0, 0, 0, 0, 1, 12'h108, 0, 0, 0, 1, 12'h101);
    checkOutput("rmw2", 0, 12'h101, 8'h00, MASTER_DISP);
    applyStimulus(0, 0, 0, 0, 0, 1, 12'h108, 0, 0, 0, 0, 0);
    checkOutput("rmw3", 0, 12'h108, 8'h00, MASTER_GPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rmw4", 0, 12'h000, 8'h00, MASTER_NONE);

    applyStimulus(1, 12'h200, 1, 12'h201, 8'h33, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw0", 1, 12'h201, 8'h33, MASTER_NONE);
    applyStimulus(1, 12'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw1", 0, 12'h200, 8'h00, MASTER_CPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw2", 0, 12'h000, 8'h00, MASTER_NONE);

    applyStimulus(0, 0, 1, 12'h300, 8'h11, 0, 0, 1, 12'h300, 8'h22, 0, 0);
    checkOutput("wc0", 1, 12'h300, 8'h22, MASTER_NONE);
    exp_conflict = 1'b1;
    applyStimulus(1, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wc1", 0, 12'h300, 8'h00, MASTER_CPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wc2", 0, 12'h000, 8'h00, MASTER_NONE);
    checkOutput("wc3", 0, 12'h000, 8'h00, MASTER_NONE);

    applyStimulus(1, 12'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rmid0", 0, 12'h200, 8'h00, MASTER_CPU);
    reset = 1'b1;
    sb.delete();
    checkOutput("rmid1", 0, 12'h000, 8'h00, MASTER_NONE);
    reset = 1'b0;
    exp_conflict = 1'b0;
    applyStimulus(1, 12'h200, 0, 0, 0, 1, 12'h100, 0, 0, 0, 0, 0);
    checkOutput("rmid2", 0, 12'h200, 8'h00, MASTER_CPU);
    applyStimulus(0, 0, 0, 0, 0, 1, 12'h100, 0, 0, 0, 0, 0);
    checkOutput("rmid3", 0, 12'h100, 8'h00, MASTER_GPU);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rmid4", 0, 12'h000, 8'h00, MASTER_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 4 KiB system RAM between three masters: the CPU, the GPU sprite engine and the display scanout reader. All three use the same read-request/ack protocol as the GPU's memory port. CPU and GPU also use its single-cycle fire-and-forget write. The block sits between those masters and the RAM macro. It owns all RAM address, write-enable and write-data muxing.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 8, RAM data width

Ports. Clocking is one clock with synchronous active-high reset.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_read  in  1  CPU read request, held until ack
- cpu_read_idx  in  ADDR_WIDTH  CPU read address
- cpu_read_ack  out  1  one-cycle pulse; cpu_read_byte valid
- cpu_read_byte  out  DATA_WIDTH  read data
- cpu_write  in  1  CPU write strobe (no ack)
- cpu_write_idx  in  ADDR_WIDTH  CPU write address
- cpu_write_byte  in  DATA_WIDTH  CPU write data
- gpu_read, gpu_read_idx, gpu_read_ack, gpu_read_byte  same as cpu_*
- gpu_write, gpu_write_idx, gpu_write_byte  same as cpu_*
- disp_read, disp_read_idx, disp_read_ack, disp_read_byte  same as cpu_*; display port is read-only
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM registered read data, valid one cycle after address
- write_conflict  out  1  sticky: cpu_write and gpu_write were high in the same cycle

## Operation
- Writes have no ack, so any write is accepted in the cycle it is asserted.
  - That cycle: ram_we=1, address and data come from the writer, and no read is granted.
  - If both CPU and GPU write, the GPU write wins, the CPU write is dropped and write_conflict is set. It stays set until reset.
- Reads are granted only in cycles with no write.
  - Eligible readers: request high and not receiving an ack this cycle. This mask is required because masters drop the request combinationally on ack.
  - Round-robin among eligible readers, fixed order CPU → GPU → DISP.
  - Search starts after the last granted reader. Pointer reset value: DISP, so the CPU has first priority after reset.
  - The pointer updates only on a read grant.
- On a read grant in cycle N, ram_addr is set to that reader's idx and ram_we=0. A registered grant tag is stored.
- In cycle N+1, exactly the tagged reader's *_read_ack=1. All *_read_byte outputs are driven from ram_rdata; only the ack qualifies them.
- Idle cycle (no write, no eligible reader): ram_addr holds 0, ram_we=0.
- At most one outstanding read at a time. A new grant in N+1 is legal because RAM is pipelined.

## Timing
- Reset values: all *_read_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, write_conflict=0, grant tag empty, RR pointer=DISP.
- Read latency: request high in cycle N with no competition and no write → ack in N+1. Minimum one-cycle request-to-ack.
- Worst-case wait with all three readers continuously requesting and no writes: a reader is granted at least once every 3 cycles.
  - Each write cycle delays reads by one cycle.
- The request must stay stable (idx unchanged) until ack. If it is dropped before grant, nothing is issued.
- Read and write from the same master in the same cycle: the write proceeds and the read waits.
- Reset asserted while a read is in flight: the ack in the following cycle is suppressed and the tag is cleared.
- Outputs ram_addr, ram_we and ram_wdata are combinational from inputs and state. Acks are registered.

## Structure
- Shared package (chip8_pkg): ADDR_WIDTH/DATA_WIDTH defaults and the master ID encoding. Encoding: MASTER_NONE=0, CPU=1, GPU=2, DISP=3. It is 2 bits wide.
- One sub-module, rr_arbiter3. It is a 3-way round-robin picker: request mask and last-grant pointer in, one-hot grant out, combinational. This keeps the pointer logic testable on its own.

## Test plan
- Single reader: CPU reads 0x200 holding 0xA2 → ram_addr=0x200 in N; cpu_read_ack=1 and cpu_read_byte=0xA2 in N+1; other acks 0.
- Contention: CPU, GPU and DISP all request from cycle 0 after reset → grants in order CPU, GPU, DISP in cycles 0, 1, 2; acks in cycles 1, 2, 3.
- Write preemption: GPU writes 0x55 to 0x108 in the same cycle DISP requests 0x100 → ram_we=1, addr 0x108; DISP granted next cycle; DISP ack one cycle later.
- GPU read-modify-write with DISP scanout running: the value read back at 0x108 equals the last GPU write. No ack is ever delivered to a master whose request is low.
- Write conflict: cpu_write (0x300, 0x11) and gpu_write (0x300, 0x22) in the same cycle → RAM holds 0x22; write_conflict=1 and stays 1 until reset.
- Reset mid-read: grant CPU in N, reset in N+1 → cpu_read_ack stays 0; all outputs return to their reset values.
